// File: rtl/mem_op_sequencer_if.sv
// Command, response, memory and operator signals of the memory/operator sequencer.
// slave = sequencer side, master = command issuer plus memory/operator environment.
interface mem_op_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_a_addr;
   logic [2:0]  cmd_b_addr;
   logic [2:0]  cmd_c_addr;
   logic        cmd_or_mode;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [2:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        op_mode;
   logic [31:0] op_c;

   modport slave (
      input  cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_or_mode,
      input  rsp_ready, mem_rdata, op_c,
      output cmd_ready, rsp_valid, rsp_data,
      output mem_addr, mem_wdata, mem_we, op_a, op_b, op_mode
   );

   modport master (
      output cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_or_mode,
      output rsp_ready, mem_rdata, op_c,
      input  cmd_ready, rsp_valid, rsp_data,
      input  mem_addr, mem_wdata, mem_we, op_a, op_b, op_mode
   );
endinterface

// File: rtl/mem_op_sequencer.sv
// Single-command sequencer: reads two operands from the 8x32 memory, runs the
// registered AND/OR unit, writes the result back and returns it on the response channel.
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for a command
// RD_A  | mem_addr=a address, operand A captured at edge
// RD_B  | mem_addr=b address, operand B captured at edge
// EXEC  | operands stable, operator registers op_c at edge
// WB    | op_c written to c address, latched into rsp_data
// RSP   | rsp_valid=1 until rsp_ready
module mem_op_sequencer (
   input  logic                 clk,
   input  logic                 rst,
   mem_op_sequencer_if.slave    bus,
   output logic                 busy,
   output logic [7:0]           done_count
);
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD_A = 3'd1;
   localparam logic [2:0] ST_RD_B = 3'd2;
   localparam logic [2:0] ST_EXEC = 3'd3;
   localparam logic [2:0] ST_WB   = 3'd4;
   localparam logic [2:0] ST_RSP  = 3'd5;

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [2:0]  a_addr_q;
   logic [2:0]  b_addr_q;
   logic [2:0]  c_addr_q;
   logic        mode_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] rsp_data_q;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.cmd_valid) state_nxt = ST_RD_A;
         ST_RD_A: state_nxt = ST_RD_B;
         ST_RD_B: state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = ST_WB;
         ST_WB:   state_nxt = ST_RSP;
         ST_RSP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         a_addr_q   <= 3'd0;
         b_addr_q   <= 3'd0;
         c_addr_q   <= 3'd0;
         mode_q     <= 1'b0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         rsp_data_q <= 32'd0;
         done_count <= 8'd0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  a_addr_q <= bus.cmd_a_addr;
                  b_addr_q <= bus.cmd_b_addr;
                  c_addr_q <= bus.cmd_c_addr;
                  mode_q   <= bus.cmd_or_mode;
               end
            end
            ST_RD_A: a_q <= bus.mem_rdata;
            ST_RD_B: b_q <= bus.mem_rdata;
            ST_WB:   rsp_data_q <= bus.op_c;
            ST_RSP:  if (bus.rsp_ready) done_count <= done_count + 8'd1;
            default: ;
         endcase
      end
   end

   // Address defaults to operand A outside the read/write states.
   always_comb begin
      bus.mem_addr = a_addr_q;
      case (state)
         ST_RD_B: bus.mem_addr = b_addr_q;
         ST_WB:   bus.mem_addr = c_addr_q;
         default: bus.mem_addr = a_addr_q;
      endcase
   end

   assign bus.cmd_ready = (state == ST_IDLE);
   assign bus.rsp_valid = (state == ST_RSP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.mem_wdata = bus.op_c;
   assign bus.mem_we    = (state == ST_WB);
   assign bus.op_a      = a_q;
   assign bus.op_b      = b_q;
   assign bus.op_mode   = mode_q;
   assign busy          = (state != ST_IDLE);
endmodule

// File: tb/tb_mem_op_sequencer.sv
// Bench for mem_op_sequencer: memory and operator models, a command-level
// reference memory, directed vectors, reset and wrap sequences, random commands.
module tb_mem_op_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       busy;
   logic [7:0] done_count;

   mem_op_sequencer_if bus();

   mem_op_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .done_count (done_count)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [8];
   logic        bd_we = 1'b0;
   logic [2:0]  bd_addr = 3'd0;
   logic [31:0] bd_data = 32'd0;
   int          we_count = 0;

   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         we_count <= we_count + 1;
      end
   end

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk)
      bus.op_c <= bus.op_mode ? (bus.op_a | bus.op_b) : (bus.op_a & bus.op_b);

   logic [31:0] ref_mem [8];
   int          exp_done = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [2:0]  a;
      logic [2:0]  b;
      logic [2:0]  c;
      logic        mode;
      int          hold;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [2:0] addr, input logic [31:0] data);
      bd_addr = addr;
      bd_data = data;
      bd_we   = 1'b1;
      step();
      bd_we   = 1'b0;
      ref_mem[addr] = data;
   endtask

   // Issue one command, optionally stall the response, and compare against the reference memory.
   task automatic run_cmd(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                          input logic mode, input int hold, output logic [31:0] got);
      logic [31:0] exp_r;
      int          lat;
      int          wc0;
      exp_r = mode ? (ref_mem[a] | ref_mem[b]) : (ref_mem[a] & ref_mem[b]);
      wc0   = we_count;
      bus.cmd_a_addr  = a;
      bus.cmd_b_addr  = b;
      bus.cmd_c_addr  = c;
      bus.cmd_or_mode = mode;
      bus.cmd_valid   = 1'b1;
      bus.rsp_ready   = 1'b0;
      check("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
      step();
      lat = 0;
      while (!bus.rsp_valid && lat < 20) begin
         check("cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
         bus.cmd_valid   = 1'($urandom_range(0, 1));
         bus.cmd_a_addr  = 3'($urandom);
         bus.cmd_b_addr  = 3'($urandom);
         bus.cmd_c_addr  = 3'($urandom);
         bus.cmd_or_mode = 1'($urandom);
         step();
         lat++;
      end
      bus.cmd_valid = 1'b0;
      check("latency", lat, 32'd4);
      got = bus.rsp_data;
      check("rsp_data", got, exp_r);
      check("mem_addr_rsp", {29'd0, bus.mem_addr}, {29'd0, a});
      for (int i = 0; i < hold; i++) begin
         step();
         check("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
         check("hold_rsp_data", bus.rsp_data, got);
         check("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
         check("hold_done_count", {24'd0, done_count}, exp_done);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      exp_done   = (exp_done + 1) % 256;
      ref_mem[c] = exp_r;
      check("done_count", {24'd0, done_count}, exp_done);
      check("rsp_valid_after", {31'd0, bus.rsp_valid}, 32'd0);
      check("cmd_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
      check("writes_per_cmd", we_count - wc0, 32'd1);
      check("mem_c", mem[c], ref_mem[c]);
   endtask

   initial begin
      logic [31:0] got;
      int          wc0;
      int          vcount;

      bus.cmd_valid   = 1'b0;
      bus.cmd_a_addr  = 3'd0;
      bus.cmd_b_addr  = 3'd0;
      bus.cmd_c_addr  = 3'd0;
      bus.cmd_or_mode = 1'b0;
      bus.rsp_ready   = 1'b0;

      vecs[0] = '{a: 3'd1, b: 3'd2, c: 3'd3, mode: 1'b0, hold: 0, exp: 32'h00F0_0000};
      vecs[1] = '{a: 3'd1, b: 3'd2, c: 3'd4, mode: 1'b1, hold: 0, exp: 32'hFFF0_FFFF};
      vecs[2] = '{a: 3'd4, b: 3'd4, c: 3'd4, mode: 1'b0, hold: 0, exp: 32'hFFF0_FFFF};
      vecs[3] = '{a: 3'd3, b: 3'd2, c: 3'd5, mode: 1'b1, hold: 3, exp: 32'h0FF0_FFFF};

      repeat (3) step();
      check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("rst_done_count", {24'd0, done_count}, 32'd0);
      check("rst_rsp_data", bus.rsp_data, 32'd0);
      rst = 1'b1;
      step();

      for (int i = 0; i < 8; i++) preload(3'(i), $urandom);
      preload(3'd1, 32'hF0F0_0000);
      preload(3'd2, 32'h0FF0_FFFF);

      for (int i = 0; i < 4; i++) begin
         run_cmd(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].mode, vecs[i].hold, got);
         check("tbl_rsp", got, vecs[i].exp);
         check("tbl_mem", mem[vecs[i].c], vecs[i].exp);
      end
      check("tbl_done", {24'd0, done_count}, 32'd4);

      // Reset while the operator is executing: no write, no response afterwards.
      wc0 = we_count;
      bus.cmd_a_addr  = 3'd1;
      bus.cmd_b_addr  = 3'd2;
      bus.cmd_c_addr  = 3'd6;
      bus.cmd_or_mode = 1'b1;
      bus.cmd_valid   = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      step();
      step();
      check("exec_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check("arst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("arst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("arst_done_count", {24'd0, done_count}, 32'd0);
      exp_done = 0;
      repeat (2) step();
      @(negedge clk) rst = 1'b1;
      vcount = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.rsp_valid) vcount++;
      end
      check("arst_no_rsp", vcount, 32'd0);
      check("arst_no_write", we_count - wc0, 32'd0);
      check("arst_mem6", mem[6], ref_mem[6]);

      // 256 random commands: counter must wrap to 0 with exactly 256 writes.
      wc0 = we_count;
      for (int n = 0; n < 256; n++) begin
         if (n % 32 == 5) preload(3'($urandom), $urandom);
         run_cmd(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                 $urandom_range(0, 2), got);
      end
      check("wrap_done_count", {24'd0, done_count}, 32'd0);
      check("wrap_writes", we_count - wc0, 32'd256);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_op_sequencer.md
# mem_op_sequencer

Command-driven controller that sequences the shared 8x32 memory and the registered AND/OR operator unit. It reads two operands from memory, issues them to the operator, writes the result back and returns it on a response channel. It replaces ad-hoc counter-driven address muxing at the top level with a single valid/ready command interface. Exactly one command is in flight at a time.

## Interface
- No parameters; memory depth 8 (3-bit address), data width 32, both fixed.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_a_addr  in  3  operand A address
- cmd_b_addr  in  3  operand B address
- cmd_c_addr  in  3  result address
- cmd_or_mode  in  1  0 = AND, 1 = OR
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  result value
- mem_addr  out  3  memory address (memory read is combinational)
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write enable (memory writes on the clock edge)
- mem_rdata  in  32  memory read data
- op_a, op_b  out  32 each  operator operands
- op_mode  out  1  operator mode
- op_c  in  32  operator result, registered one cycle after operands/mode
- busy  out  1  state != IDLE
- done_count  out  8  completed commands, wraps 255 -> 0

## Operation
- FSM states: IDLE, RD_A, RD_B, EXEC, WB, RSP.
- IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch a/b/c addresses and mode, then go to RD_A.
- RD_A: mem_addr=a_addr_q; capture mem_rdata into a_q at the edge; go to RD_B.
- RD_B: mem_addr=b_addr_q; capture mem_rdata into b_q; go to EXEC.
- EXEC: op_a=a_q, op_b=b_q, op_mode=mode_q are stable; the operator registers op_c at the edge; go to WB.
- WB: mem_addr=c_addr_q, mem_wdata=op_c, mem_we=1. Latch op_c into rsp_data. Go to RSP.
- RSP: rsp_valid=1. Hold the state and rsp_data until rsp_ready=1. On that handshake edge, increment done_count and go to IDLE.
- op_a, op_b and op_mode are driven from a_q, b_q and mode_q in every state.
- mem_addr in IDLE/RSP is a_addr_q. mem_wdata is op_c in all states; only mem_we qualifies it.
- mem_we is 1 only in WB. Exactly one write per command.
- Address aliasing (a=b, a=c, b=c, all equal) needs no special handling:
  - reads complete before WB;
  - a later command reading c_addr sees the new value.
- cmd_ready=0 outside IDLE. cmd_valid is ignored there, and command fields may change freely.
- Reset (rst=0, any state, including mid-WB) asynchronously sets:
  - state to IDLE;
  - mem_we=0, rsp_valid=0, busy=0, cmd_ready=1 (combinational from IDLE);
  - a_q, b_q, rsp_data, all latched addresses, mode_q and done_count to 0.
- Reset during WB: whether the in-progress write completes is undefined. No response is produced.

## Timing
- Handshake at edge T0 produces:
  - RD_A during cycle T0..T1, RD_B T1..T2, EXEC T2..T3, WB T3..T4;
  - rsp_valid=1 from T4.
- With rsp_ready held at 1, the response handshake occurs at edge T5 and cmd_ready=1 again after T5. The next command can be accepted at T6.
- Minimum spacing between command accepts is 6 cycles. Latency from accept to rsp_valid is 4 cycles.
- rsp_valid and rsp_data are stable while rsp_ready=0.
- The memory write at edge T4 is visible on mem_rdata from T4 onward.
- done_count updates at the response handshake edge.

## Test plan
- AND: mem[1]=0xF0F0_0000, mem[2]=0x0FF0_FFFF, cmd a=1 b=2 c=3 mode=0 -> rsp_data=0x00F0_0000 four cycles after accept; mem[3]=0x00F0_0000; done_count=1.
- OR: same operands, c=4, mode=1 -> rsp_data=0xFFF0_FFFF and mem[4]=0xFFF0_FFFF. Then cmd a=4 b=4 c=4 mode=0 -> mem[4] unchanged, rsp_data=0xFFF0_FFFF.
- Backpressure: hold rsp_ready=0 for 3 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, done_count unchanged; it increments one cycle after rsp_ready rises.
- Command while busy: pulse cmd_valid with different fields during RD_B -> ignored, no extra memory write, response matches the original command.
- Reset mid-operation: assert rst=0 asynchronously during EXEC -> mem_we, rsp_valid and busy go to 0 immediately, done_count=0, cmd_ready=1. No response issued after release.
- Counter wrap: complete 256 commands back-to-back -> done_count reads 0; mem_we asserted exactly 256 times.
